// File: rtl/pwm_decoder.sv
// ---------------------------------------------------------------------------
// PwmDecoder: receive-side counterpart of the PWM generator.
//
// Samples an asynchronous PWM line, measures high time (H) and period (P)
// between consecutive rising edges and converts the duty cycle to a level
// 0..10 (tenths, rounded to nearest). The level is shown on the same
// active-low seven-segment format {dp,g,f,e,d,c,b,a} the generator uses.
// A line that stops toggling is reported as level 10 (stuck high) or
// level 0 (stuck low) after TIMEOUT_CYCLES.
//
// Optional build macro: PWM_DEC_GLITCH_FILTER_EN
//   When defined, the synchronized line must hold a new value for
//   FILTER_CYCLES consecutive clocks before it is accepted.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   pwm_in       external PWM line (asynchronous to clk)
//   level        decoded duty level 0..10
//   level_valid  one-cycle pulse when level is updated
//   locked       high while level reflects a current measurement
//   err          sticky flag: a period shorter than PERIOD_MIN was seen
//   out_display  seven-segment code of level (dash while unlocked)
// ---------------------------------------------------------------------------
module pwm_decoder #(
    parameter int PERIOD_MIN     = 16,
    parameter int TIMEOUT_CYCLES = 4000,
    parameter int CNT_W          = 16,
    parameter int FILTER_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [3:0] level,
    output logic       level_valid,
    output logic       locked,
    output logic       err,
    output logic [7:0] out_display
);

    // Numerator 10*H + P/2 needs four extra bits over the counters.
    localparam int DIV_W = CNT_W + 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_DIVIDE  = 2'd2;
    localparam logic [1:0] ST_STEADY  = 2'd3;

    logic             sync_1, sync_2;
    logic             line, line_d;
    logic             rise;
    logic [CNT_W-1:0] per_cnt, hi_cnt;
    logic [1:0]       state;
    logic [DIV_W-1:0] rem;
    logic [CNT_W-1:0] div_p;
    logic [3:0]       quot;

    // Two-flop synchronizer for the asynchronous PWM pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= pwm_in;
            sync_2 <= sync_1;
        end
    end

`ifdef PWM_DEC_GLITCH_FILTER_EN
    localparam int FLT_W = $clog2(FILTER_CYCLES + 1);

    logic             line_q;
    logic [FLT_W-1:0] flt_cnt;

    // The filtered line only follows the synchronizer once the new value has
    // been present for FILTER_CYCLES consecutive clocks; any return to the
    // current value restarts the count, so short pulses vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q  <= 1'b0;
            flt_cnt <= '0;
        end else if (sync_2 == line_q) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FLT_W'(FILTER_CYCLES - 1)) begin
            line_q  <= sync_2;
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    assign line = line_q;
`else
    assign line = sync_2;
`endif

    assign rise = line & ~line_d;

    // Edge-detect register plus free-running saturating period/high counters.
    // A rising edge restarts both at 1 because that cycle already belongs to
    // the new period and the line is high in it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_d  <= 1'b0;
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            line_d <= line;
            if (rise) begin
                per_cnt <= CNT_W'(1);
                hi_cnt  <= CNT_W'(1);
            end else begin
                if (per_cnt != '1) per_cnt <= per_cnt + 1'b1;
                if (line && hi_cnt != '1) hi_cnt <= hi_cnt + 1'b1;
            end
        end
    end

    // Measurement FSM. The divider works on latched copies of H and P so the
    // counters keep running; each DIVIDE cycle subtracts P once from
    // 10*H + P/2, which yields the rounded quotient in at most 11 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            level       <= 4'd0;
            level_valid <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
            rem         <= '0;
            div_p       <= '0;
            quot        <= 4'd0;
        end else begin
            level_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) state <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (rise) begin
                        if (per_cnt < CNT_W'(PERIOD_MIN)) begin
                            err <= 1'b1;
                        end else begin
                            rem   <= (DIV_W'(hi_cnt) << 3) + (DIV_W'(hi_cnt) << 1)
                                     + DIV_W'(per_cnt >> 1);
                            div_p <= per_cnt;
                            quot  <= 4'd0;
                            state <= ST_DIVIDE;
                        end
                    end else if (per_cnt >= CNT_W'(TIMEOUT_CYCLES)) begin
                        level       <= line ? 4'd10 : 4'd0;
                        level_valid <= 1'b1;
                        locked      <= 1'b1;
                        state       <= ST_STEADY;
                    end
                end
                ST_DIVIDE: begin
                    if (rem >= DIV_W'(div_p) && quot < 4'd10) begin
                        rem  <= rem - DIV_W'(div_p);
                        quot <= quot + 1'b1;
                    end else begin
                        level       <= quot;
                        level_valid <= 1'b1;
                        locked      <= 1'b1;
                        state       <= ST_MEASURE;
                    end
                end
                default: begin
                    if (rise) state <= ST_MEASURE;
                end
            endcase
        end
    end

    // Display register follows level one cycle later; dash while unlocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_display <= 8'hBF;
        end else if (!locked) begin
            out_display <= 8'hBF;
        end else begin
            case (level)
                4'd0:    out_display <= 8'hC0;
                4'd1:    out_display <= 8'hF9;
                4'd2:    out_display <= 8'hA4;
                4'd3:    out_display <= 8'hB0;
                4'd4:    out_display <= 8'h99;
                4'd5:    out_display <= 8'h92;
                4'd6:    out_display <= 8'h82;
                4'd7:    out_display <= 8'hF8;
                4'd8:    out_display <= 8'h80;
                4'd9:    out_display <= 8'h90;
                4'd10:   out_display <= 8'h88;
                default: out_display <= 8'hBF;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// ---------------------------------------------------------------------------
// Testbench for pwm_decoder. A stimulus process drives PWM periods on the pin
// and pushes the level each completed period should produce into a
// scoreboard queue; a monitor pops and compares whenever level_valid pulses.
// ---------------------------------------------------------------------------
module tb_pwm_decoder;

    localparam int PERIOD_MIN = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwm_in;
    logic [3:0] level;
    logic       level_valid;
    logic       locked;
    logic       err;
    logic [7:0] out_display;

    pwm_decoder #(
        .PERIOD_MIN    (PERIOD_MIN),
        .TIMEOUT_CYCLES(4000),
        .CNT_W         (16),
        .FILTER_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .level      (level),
        .level_valid(level_valid),
        .locked     (locked),
        .err        (err),
        .out_display(out_display)
    );

    always #10 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    typedef struct packed {
        int lvl;
        int t_min;
        int t_max;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         passes = 0;
    bit         have_prev = 0;
    int         prev_h, prev_p;
    bit         err_exp = 0;
    logic [7:0] seg_tab [11];

    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                    8'h82, 8'hF8, 8'h80, 8'h90, 8'h88};
    end

    // Reference: rounded tenths of the duty cycle, capped at 10.
    function automatic int modelLevel(int h, int p);
        int q;
        q = (10 * h + p / 2) / p;
        if (q > 10) q = 10;
        return q;
    endfunction

    task automatic checkOutput(string name, int act, int req);
        checks++;
        if (act == req) passes++;
        else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                      name, act, act, req, req);
    endtask

    // Called at every pin rising edge: the previous period is now complete.
    task automatic endPeriod();
        exp_t e;
        if (have_prev) begin
            if (prev_p < PERIOD_MIN) begin
                err_exp = 1'b1;
            end else begin
                e.lvl   = modelLevel(prev_h, prev_p);
                e.t_min = cycle + 3;
                e.t_max = cycle + 22;
                sb.push_back(e);
            end
        end
    endtask

    // One period starting with a rising edge; entered and left at a negedge.
    task automatic applyStimulus(int h, int p);
        pwm_in = 1'b1;
        endPeriod();
        have_prev = 1'b1;
        prev_h    = h;
        prev_p    = p;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    // Rising edge followed by a line that stops toggling.
    task automatic applyHold(bit high);
        exp_t e;
        pwm_in = 1'b1;
        endPeriod();
        have_prev = 1'b0;
        e.lvl   = high ? 10 : 0;
        e.t_min = cycle + 3990;
        e.t_max = cycle + 4020;
        sb.push_back(e);
        if (high) begin
            repeat (5000) @(negedge clk);
            pwm_in = 1'b0;
            repeat (50) @(negedge clk);
        end else begin
            repeat (100) @(negedge clk);
            pwm_in = 1'b0;
            repeat (4900) @(negedge clk);
        end
    endtask

    // 500-high / 1000 period with a 2-cycle low glitch at offset 10.
    task automatic applyGlitchPeriod();
        pwm_in = 1'b1;
        endPeriod();
        have_prev = 1'b1;
`ifdef PWM_DEC_GLITCH_FILTER_EN
        prev_h = 500;
        prev_p = 1000;
`else
        prev_h = 10;
        prev_p = 12;
`endif
        repeat (10) @(negedge clk);
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        pwm_in = 1'b1;
`ifndef PWM_DEC_GLITCH_FILTER_EN
        endPeriod();
        prev_h = 488;
        prev_p = 988;
`endif
        repeat (488) @(negedge clk);
        pwm_in = 1'b0;
        repeat (500) @(negedge clk);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 6000 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() == 0) passes++;
        else $display("[TB] FAIL drain: %0d expected updates never arrived, required 0",
                      sb.size());
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops on every level_valid and checks level, lock, latency,
    // then the display code and single-cycle pulse on the following cycle.
    bit disp_pending = 1'b0;
    int disp_exp     = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            disp_pending = 1'b0;
        end else if (disp_pending) begin
            checkOutput("display", int'(out_display), int'(seg_tab[disp_exp]));
            checkOutput("valid_pulse_width", int'(level_valid), 0);
            disp_pending = 1'b0;
        end else if (level_valid) begin
            if (sb.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_valid: level_valid with level %0d, required no update",
                         level);
            end else begin
                e = sb.pop_front();
                checkOutput("level", int'(level), e.lvl);
                checkOutput("locked", int'(locked), 1);
                checks++;
                if (cycle >= e.t_min && cycle <= e.t_max) passes++;
                else $display("[TB] FAIL latency: update at cycle %0d, required %0d..%0d",
                              cycle, e.t_min, e.t_max);
                disp_pending = 1'b1;
                disp_exp     = e.lvl;
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int p, h;
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset_level", int'(level), 0);
        checkOutput("reset_valid", int'(level_valid), 0);
        checkOutput("reset_locked", int'(locked), 0);
        checkOutput("reset_err", int'(err), 0);
        checkOutput("reset_display", int'(out_display), 8'hBF);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] directed duty cycles");
        applyStimulus(300, 1000);
        applyStimulus(350, 1000);
        applyStimulus(349, 1000);
        applyStimulus(500, 1000);
        waitDrain();
        checkOutput("err_clean", int'(err), int'(err_exp));

        $display("[TB] random periods");
        for (int i = 0; i < 20; i++) begin
            p = int'($urandom_range(100, 800));
            h = int'($urandom_range(8, p - 8));
            applyStimulus(h, p);
        end
        waitDrain();

        $display("[TB] steady high then steady low");
        applyHold(1'b1);
        waitDrain();
        checkOutput("steady_high_locked", int'(locked), 1);
        applyHold(1'b0);
        waitDrain();

        $display("[TB] short periods");
        applyStimulus(600, 1000);
        applyStimulus(300, 1000);
        for (int i = 0; i < 3; i++) applyStimulus(5, 10);
        applyStimulus(300, 1000);
        applyStimulus(500, 1000);
        waitDrain();
        checkOutput("err_short", int'(err), int'(err_exp));

        $display("[TB] glitch inside high phase");
        applyGlitchPeriod();
        applyStimulus(500, 1000);
        applyStimulus(300, 1000);
        waitDrain();
        checkOutput("err_glitch", int'(err), int'(err_exp));

        $display("[TB] reset during divide");
        applyStimulus(600, 1000);
        pwm_in = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset_level", int'(level), 0);
        checkOutput("midreset_locked", int'(locked), 0);
        checkOutput("midreset_valid", int'(level_valid), 0);
        checkOutput("midreset_err", int'(err), 0);
        checkOutput("midreset_display", int'(out_display), 8'hBF);
        sb.delete();
        have_prev = 1'b0;
        err_exp   = 1'b0;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        pwm_in = 1'b0;
        repeat (20) @(negedge clk);
        applyStimulus(400, 1000);
        applyStimulus(700, 1000);
        applyStimulus(100, 1000);
        pwm_in = 1'b1;
        endPeriod();
        repeat (30) @(negedge clk);
        pwm_in = 1'b0;
        waitDrain();
        checkOutput("err_after_reset", int'(err), int'(err_exp));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
